// File: rtl/bcd2bin.sv
// Five-digit BCD to 16-bit binary converter using reverse double-dabble.
// Performs one shift-and-correct step per clock and reports overflow or bad digits on err.
module bcd2bin (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  BCD0,
  input  logic [3:0]  BCD1,
  input  logic [3:0]  BCD2,
  input  logic [3:0]  BCD3,
  input  logic [3:0]  BCD4,
  output logic [15:0] x,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e      state_q, state_d;
  logic [35:0] sr_q, sr_d, sr_sh, sr_fix;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] x_q, x_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        digits_ok;

  assign digits_ok = (BCD0 <= 4'd9) && (BCD1 <= 4'd9) && (BCD2 <= 4'd9) &&
                     (BCD3 <= 4'd9) && (BCD4 <= 4'd9);

  // Shift right, then pull 3 from every BCD nibble that now reads 8 or more.
  always_comb begin
    sr_sh  = {1'b0, sr_q[35:1]};
    sr_fix = sr_sh;
    for (int i = 0; i < 5; i++) begin
      if (sr_sh[19 + 4*i]) begin
        sr_fix[16 + 4*i +: 4] = sr_sh[16 + 4*i +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    err_d   = err_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (digits_ok) begin
            sr_d    = {BCD4, BCD3, BCD2, BCD1, BCD0, 16'b0};
            cnt_d   = 5'd0;
            busy_d  = 1'b1;
            state_d = StConv;
          end else begin
            x_d     = 16'd0;
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StDone;
          end
        end
      end
      StConv: begin
        sr_d  = sr_fix;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd15) begin
          x_d     = sr_fix[15:0];
          err_d   = |sr_fix[35:16];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      sr_q    <= 36'd0;
      cnt_q   <= 5'd0;
      x_q     <= 16'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign x    = x_q;
  assign err  = err_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_bcd2bin.sv
// Scoreboard bench for bcd2bin: directed digit vectors, expected results queued at issue
// and popped by a done-driven monitor.
module tb_bcd2bin;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  BCD0 = 4'd0, BCD1 = 4'd0, BCD2 = 4'd0, BCD3 = 4'd0, BCD4 = 4'd0;
  logic [15:0] x;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [16:0] exp_q[$];

  bcd2bin dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .BCD0  (BCD0),
    .BCD1  (BCD1),
    .BCD2  (BCD2),
    .BCD3  (BCD3),
    .BCD4  (BCD4),
    .x     (x),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic set_digits(input logic [19:0] d);
    {BCD4, BCD3, BCD2, BCD1, BCD0} = d;
  endtask

  // Presents digits with a one-cycle start; returns at the sample just after the start edge.
  task automatic issue(input logic [19:0] d, input bit expect_done,
                       input logic [15:0] ex, input logic ee);
    @(negedge clk);
    set_digits(d);
    start = 1'b1;
    if (expect_done) exp_q.push_back({ex, ee});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int bc);
    lat = 1;
    bc  = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic run_vec(input string name, input logic [19:0] d,
                         input logic [15:0] ex, input logic ee);
    int lat, bc;
    issue(d, 1'b1, ex, ee);
    wait_done(lat, bc);
    check({name, "_latency"}, lat, 32'd17);
    check({name, "_busy_cycles"}, bc, 32'd16);
    @(negedge clk);
  endtask

  initial begin
    int lat, bc;
    int t0, t1, t2;
    bit prev_done;

    // Monitor: pops the scoreboard on every done and flags stretched pulses.
    fork
      begin
        prev_done = 1'b0;
        forever begin
          @(negedge clk);
          if (done) begin
            check("done_width", {31'd0, prev_done}, 32'd0);
            if (exp_q.size() == 0) begin
              check("unexpected_done", 32'd1, 32'd0);
            end else begin
              logic [16:0] e;
              e = exp_q.pop_front();
              check("result", {15'd0, x, err}, {15'd0, e});
            end
          end
          prev_done = done;
        end
      end
    join_none

    #2;
    check("reset_outputs", {15'd0, x, err, done, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_vec("zero", 20'h00000, 16'h0000, 1'b0);
    run_vec("max_ok", 20'h65535, 16'hFFFF, 1'b0);
    run_vec("over1", 20'h65536, 16'h0000, 1'b1);
    run_vec("all9", 20'h99999, 16'h869F, 1'b1);
    run_vec("v10000", 20'h10000, 16'h2710, 1'b0);
    run_vec("v40960", 20'h40960, 16'hA000, 1'b0);

    // Inputs change mid-conversion and a second start arrives; neither may matter.
    issue(20'h12345, 1'b1, 16'h3039, 1'b0);
    repeat (4) @(negedge clk);
    set_digits(20'h99999);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bc);
    @(negedge clk);
    repeat (20) @(negedge clk);
    check("ignored_start_busy", {31'd0, busy}, 32'd0);

    // Invalid digit: immediate done, no busy.
    issue(20'h00A00, 1'b1, 16'h0000, 1'b1);
    check("bad_digit_done_next", {31'd0, done}, 32'd1);
    check("bad_digit_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("bad_digit_pulse_end", {30'd0, done, busy}, 32'd0);
    issue(20'hF0000, 1'b1, 16'h0000, 1'b1);
    check("bad_top_digit_done", {31'd0, done}, 32'd1);
    @(negedge clk);

    // Reset mid-conversion aborts without a done pulse.
    issue(20'h54321, 1'b0, 16'h0, 1'b0);
    repeat (6) @(negedge clk);
    check("pre_abort_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_outputs", {15'd0, x, err, done, busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("abort_no_resume", {30'd0, busy, done}, 32'd0);
    run_vec("after_reset", 20'h00042, 16'h002A, 1'b0);

    // Start held high: a new conversion every 18 cycles.
    set_digits(20'h00007);
    repeat (3) exp_q.push_back({16'h0007, 1'b0});
    @(negedge clk);
    start = 1'b1;
    wait_done(lat, bc);
    t0 = cyc;
    @(negedge clk);
    wait_done(lat, bc);
    t1 = cyc;
    @(negedge clk);
    wait_done(lat, bc);
    t2 = cyc;
    start = 1'b0;
    check("b2b_period_a", t1 - t0, 32'd18);
    check("b2b_period_b", t2 - t1, 32'd18);
    repeat (25) @(negedge clk);
    check("b2b_stopped", {31'd0, busy}, 32'd0);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd2bin.md
BCD2BIN -- requirements
Module: bcd2bin

Interface
REQ-001 Module SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request: convert the digits presented this cycle.
REQ-005 BCD0..BCD4  input  4 each  decimal digits, BCD0 = units … BCD4 = ten-thousands.
REQ-006 x  output  16  binary result, registered.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse: x and err are valid.
REQ-009 err  output  1  result invalid: bad digit or value > 65535; valid with done.

Function
REQ-010 Block SHALL convert a 5-digit BCD value V (0..99999) to binary using reverse double-dabble.
  - One right-shift per clock.
  - Per-digit correction: any nibble >= 8 after the shift gets 3 subtracted.
REQ-011 FSM SHALL have three states: IDLE, CONV, DONE.
REQ-012 IDLE, start=1, all digits <= 9:
  - capture {BCD4..BCD0, 16'b0} into a 36-bit shift register.
  - clear the 5-bit shift counter.
  - go to CONV; busy <= 1.
REQ-013 IDLE, start=1, any digit > 9:
  - no conversion.
  - go to DONE with x <= 0, err <= 1, done <= 1, busy <= 0.
  - done is visible one cycle after the start edge.
REQ-014 Each CONV edge:
  - shift register >> 1 (zero in at bit 35).
  - subtract 3 from each of the five nibbles [35:32],[31:28],[27:24],[23:20],[19:16] whose value >= 8.
  - counter + 1.
REQ-015 On the 16th CONV edge the block SHALL do all of the following in the same edge:
  - x <= post-correction shift register bits [15:0] (= V mod 65536).
  - err <= 1 if bits [35:16] are nonzero (V > 65535), else 0.
  - done <= 1, busy <= 0, go to DONE.
REQ-016 Latency: the valid conversion edge is edge 0; done SHALL be high in the cycle after edge 16 (a 16-cycle latency).
REQ-017 DONE SHALL last exactly one cycle; the next edge clears done and returns to IDLE.
REQ-018 Only IDLE accepts start; start in CONV or DONE SHALL be ignored and not queued.
REQ-019 Digit inputs SHALL be sampled only at the accepting start edge; changes during CONV SHALL NOT affect the result.
REQ-020 x and err SHALL hold their last values from the DONE edge until the next DONE edge.
REQ-021 Bit widths:
  - Nibble subtraction is 4-bit and never underflows (applied only when >= 8).
  - The counter saturates nowhere: CONV always exits at count 16.

Reset
REQ-022 While reset is high, the block SHALL asynchronously force:
  - state = IDLE, x = 0, err = 0, done = 0, busy = 0.
  - shift register = 0, counter = 0.
REQ-023 Reset asserted mid-conversion SHALL abort it; no done pulse for that conversion.
REQ-024 After reset, the first clock edge with reset low and start=1 SHALL be accepted normally.

Verification
REQ-025 Digits 0,0,0,0,0, start pulse → busy high for 16 cycles, then done=1, x=0x0000, err=0.
REQ-026 Digits (BCD4..BCD0) 1,2,3,4,5 → after 16 cycles x=0x3039 (12345), err=0.
  - Inputs change to 9,9,9,9,9 at cycle 5: result unchanged.
  - Second start at cycle 8: ignored.
REQ-027 Digits 6,5,5,3,5 → x=0xFFFF, err=0.
  - Digits 6,5,5,3,6 → x=0x0000, err=1.
  - Digits 9,9,9,9,9 → x=0x869F, err=1.
REQ-028 Digit BCD2=0xA, start → done=1 one cycle after the start edge, x=0, err=1, busy never high.
REQ-029 Start 54321, assert reset at cycle 8 for 2 cycles → all outputs 0, no done pulse.
  - Then start 00042 → x=0x002A, err=0 after 16 cycles.
REQ-030 Back-to-back: start held high continuously → a new conversion begins on the IDLE edge after each DONE cycle (period 18 cycles), each done exactly one cycle wide.
